bank_reader: RTL and testbench

- Read-side controller for the two-bank (ping-pong) capture RAM; the capture controller writes one bank while this block drains the other.
- Starts a readout job on a bank-full pulse or a capture-completed pulse.
- Issues sequential RAM reads and streams samples to the downstream spectrogram/transfer logic over a valid/ready interface, with last-sample marking.
- Queues one job while busy and flags an overrun when a second one arrives.

---
 rtl/bank_reader.sv | 201 ++++++++++++++++++++
 tb/tb_bank_reader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_reader.sv
// bank_reader: read-side controller for the two-bank (ping-pong) capture RAM.
// A bank-full or capture-completed pulse starts a readout job that reads the
// selected bank sequentially and streams the samples over valid/ready with a
// last-sample marker. One job can be queued while busy; further events are
// dropped and flagged by the sticky overrun bit.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   bank0_full, bank1_full  1-cycle pulses: bank holds BANK_DEPTH samples
//   memorization_completed  1-cycle pulse: partial capture ended
//   partial_bank, idx_final bank / last written index of the partial capture
//   rd_en, rd_addr, rd_data RAM read port ({bank, idx}); data one cycle later
//   m_data, m_valid, m_ready, m_last  output sample stream
//   busy                    job active or pending
//   overrun                 sticky: an event was dropped
module bank_reader #(
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 8,
    parameter int BANK_DEPTH = 200
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bank0_full,
    input  logic              bank1_full,
    input  logic              memorization_completed,
    input  logic              partial_bank,
    input  logic [IDX_W-1:0]  idx_final,
    output logic              rd_en,
    output logic [IDX_W:0]    rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    // Jobs are stored as their last index (length-1) so a full bank fits IDX_W bits.
    localparam logic [IDX_W-1:0] FULL_LAST = IDX_W'(BANK_DEPTH - 1);

    state_t             state, state_nx;
    logic               job_bank, job_bank_nx;
    logic [IDX_W-1:0]   job_last, job_last_nx;
    logic [IDX_W-1:0]   rd_idx, rd_idx_nx;
    logic               pend_vld, pend_vld_nx;
    logic               pend_bank, pend_bank_nx;
    logic [IDX_W-1:0]   pend_last, pend_last_nx;
    logic               ovr_set;

    logic [2:0]         ev;
    logic [2:0]         ev_bank;
    logic [IDX_W-1:0]   ev_last [3];
    logic               starting, job_used, slot_full;

    // Output buffer: 2 entries plus one read in flight.
    logic [DATA_W-1:0]  fifo_data [2];
    logic [1:0]         fifo_lst;
    logic               wr_ptr, rd_ptr;
    logic [1:0]         count;
    logic               fl_vld, fl_last;
    logic               pop, last_beat;
    logic [2:0]         occ;

    assign pop       = m_valid && m_ready;
    assign last_beat = pop && m_last;
    assign m_valid   = (count != 2'd0);
    assign m_data    = fifo_data[rd_ptr];
    assign m_last    = fifo_lst[rd_ptr];
    assign rd_addr   = {job_bank, rd_idx};
    assign busy      = (state != IDLE) || pend_vld;

    // Occupancy after this cycle's pop; lets a read issue every cycle at full rate
    // while never exceeding two buffered-or-in-flight samples.
    assign occ   = 3'(count) + 3'(fl_vld) - 3'(pop);
    assign rd_en = (state == READ) && (occ < 3'd2);

    always_comb begin
        ev         = {memorization_completed, bank1_full, bank0_full};
        ev_bank    = {partial_bank, 1'b1, 1'b0};
        ev_last[0] = FULL_LAST;
        ev_last[1] = FULL_LAST;
        ev_last[2] = (idx_final > FULL_LAST) ? FULL_LAST : idx_final;
    end

    always_comb begin
        state_nx     = state;
        job_bank_nx  = job_bank;
        job_last_nx  = job_last;
        rd_idx_nx    = rd_idx;
        pend_vld_nx  = pend_vld;
        pend_bank_nx = pend_bank;
        pend_last_nx = pend_last;
        ovr_set      = 1'b0;
        job_used     = 1'b0;
        slot_full    = pend_vld;
        // A new job can begin from IDLE or on the final beat of the current one.
        starting     = (state == IDLE) || ((state == DRAIN) && last_beat);

        // A queued job takes precedence and frees the slot for a same-cycle event.
        if (starting && pend_vld) begin
            job_bank_nx = pend_bank;
            job_last_nx = pend_last;
            job_used    = 1'b1;
            slot_full   = 1'b0;
            pend_vld_nx = 1'b0;
        end

        // Events in priority order: start job, else fill slot, else drop.
        for (int i = 0; i < 3; i++) begin
            if (ev[i]) begin
                if (starting && !job_used) begin
                    job_bank_nx = ev_bank[i];
                    job_last_nx = ev_last[i];
                    job_used    = 1'b1;
                end else if (!slot_full) begin
                    pend_bank_nx = ev_bank[i];
                    pend_last_nx = ev_last[i];
                    pend_vld_nx  = 1'b1;
                    slot_full    = 1'b1;
                end else begin
                    ovr_set = 1'b1;
                end
            end
        end

        case (state)
            IDLE: begin
                if (job_used) begin
                    state_nx  = READ;
                    rd_idx_nx = '0;
                end
            end
            READ: begin
                if (rd_en) begin
                    if (rd_idx == job_last) state_nx = DRAIN;
                    else rd_idx_nx = rd_idx + 1'b1;
                end
            end
            DRAIN: begin
                if (last_beat) begin
                    if (job_used) begin
                        state_nx  = READ;
                        rd_idx_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            job_bank  <= 1'b0;
            job_last  <= '0;
            rd_idx    <= '0;
            pend_vld  <= 1'b0;
            pend_bank <= 1'b0;
            pend_last <= '0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nx;
            job_bank  <= job_bank_nx;
            job_last  <= job_last_nx;
            rd_idx    <= rd_idx_nx;
            pend_vld  <= pend_vld_nx;
            pend_bank <= pend_bank_nx;
            pend_last <= pend_last_nx;
            overrun   <= overrun | ovr_set;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fl_vld       <= 1'b0;
            fl_last      <= 1'b0;
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_lst     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= '0;
        end else begin
            fl_vld  <= rd_en;
            fl_last <= rd_en && (rd_idx == job_last);
            if (fl_vld) begin
                fifo_data[wr_ptr] <= rd_data;
                fifo_lst[wr_ptr]  <= fl_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(fl_vld) - 2'(pop);
        end
    end

endmodule

// File: tb/tb_bank_reader.sv
// Directed testbench for bank_reader: RAM model, stream monitor and one task
// per scenario with hand-derived expectations.
module tb_bank_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        bank0_full, bank1_full, memorization_completed, partial_bank;
    logic [7:0]  idx_final;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] m_data;
    logic        m_valid, m_ready, m_last, busy, overrun;

    int errors = 0;
    int checks = 0;

    bank_reader dut (
        .clk(clk), .reset(reset),
        .bank0_full(bank0_full), .bank1_full(bank1_full),
        .memorization_completed(memorization_completed),
        .partial_bank(partial_bank), .idx_final(idx_final),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Sample value stored at RAM address a.
    function automatic logic [15:0] ram_val(input int a);
        logic [8:0] a9;
        a9 = 9'(a);
        return {7'h2B, a9};
    endfunction

    always @(posedge clk) if (rd_en) rd_data <= ram_val(int'(rd_addr));

    // Monitor: records reads and transferred beats with cycle stamps,
    // occupancy and stall-stability violations.
    logic [8:0]  addr_q[$];
    logic [16:0] beat_q[$];
    int          acyc_q[$], bcyc_q[$];
    int          cyc = 0, iss = 0, xfer = 0, occ_err = 0, stab_err = 0;
    logic        prev_stall = 0;
    logic [15:0] prev_d;
    logic        prev_l;
    logic        rand_rdy = 0;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (!reset) begin
            if (iss - xfer > 2) occ_err++;
            if (prev_stall && (!m_valid || m_data !== prev_d || m_last !== prev_l)) stab_err++;
            if (rd_en) begin addr_q.push_back(rd_addr); acyc_q.push_back(cyc); iss++; end
            if (m_valid && m_ready) begin beat_q.push_back({m_last, m_data}); bcyc_q.push_back(cyc); xfer++; end
            prev_stall = m_valid && !m_ready;
            prev_d = m_data;
            prev_l = m_last;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) m_ready = 1'($urandom_range(0, 1));
    end

    task automatic clear_mon();
        addr_q.delete(); beat_q.delete(); acyc_q.delete(); bcyc_q.delete();
        iss = 0; xfer = 0; occ_err = 0; stab_err = 0; prev_stall = 0;
    endtask

    // One-cycle event pulse; returns at cycle 1 (one cycle after the event).
    task automatic pulse(input logic b0, input logic b1, input logic mc,
                         input logic pb, input logic [7:0] idx);
        @(posedge clk); #1;
        bank0_full = b0; bank1_full = b1; memorization_completed = mc;
        partial_bank = pb; idx_final = idx;
        @(posedge clk); #1;
        bank0_full = 0; bank1_full = 0; memorization_completed = 0;
    endtask

    task automatic wait_done(input int budget, output logic ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && !m_valid) begin ok = 1; break; end
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output logic ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (beat_q.size() >= n) begin ok = 1; break; end
        end
    endtask

    // Mismatch counts of n beats / reads starting at queue position p, addresses base..
    function automatic int beat_bad(input int p, input int n, input int base);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (p + i >= beat_q.size() || beat_q[p+i] !== {(i == n-1), ram_val(base + i)}) bad++;
        return bad;
    endfunction

    function automatic int addr_bad(input int p, input int n, input int base);
        int bad = 0;
        for (int i = 0; i < n; i++)
            if (p + i >= addr_q.size() || addr_q[p+i] !== 9'(base + i)) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        reset = 1;
        bank0_full = 0; bank1_full = 0; memorization_completed = 0;
        partial_bank = 0; idx_final = 0; m_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rd_en !== 1'b0)    begin errors++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
        checks++; if (rd_addr !== 9'd0)  begin errors++; $display("FAIL reset_rd_addr got %0d want 0", rd_addr); end
        checks++; if (m_valid !== 1'b0)  begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_last !== 1'b0)   begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
        checks++; if (m_data !== 16'd0)  begin errors++; $display("FAIL reset_m_data got %h want 0", m_data); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (overrun !== 1'b0)  begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        #1 reset = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_full_bank0();
        logic ok;
        int consec = 0;
        clear_mon();
        m_ready = 1;
        pulse(1, 0, 0, 0, 0);
        @(negedge clk);  // cycle 1
        checks++; if ({rd_en, rd_addr} !== {1'b1, 9'd0}) begin errors++; $display("FAIL lat_rd1 got en=%b addr=%0d want en=1 addr=0", rd_en, rd_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy got %b want 1", busy); end
        @(negedge clk);  // cycle 2
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL lat_c2_valid got %b want 0", m_valid); end
        @(negedge clk);  // cycle 3
        checks++; if ({m_valid, m_data} !== {1'b1, ram_val(0)}) begin errors++; $display("FAIL lat_c3 got v=%b d=%h want v=1 d=%h", m_valid, m_data, ram_val(0)); end
        wait_beats(200, 1000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL full_timeout got %0d beats want 200", beat_q.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_last got %b want 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
        repeat (3) @(negedge clk);
        for (int i = 1; i < acyc_q.size(); i++) if (acyc_q[i] != acyc_q[i-1] + 1) consec++;
        checks++; if (addr_bad(0, 200, 0) + consec != 0 || addr_q.size() != 200)
            begin errors++; $display("FAIL full_addrs got %0d reads, %0d bad want 200 consecutive 0..199", addr_q.size(), addr_bad(0, 200, 0) + consec); end
        checks++; if (beat_bad(0, 200, 0) != 0 || beat_q.size() != 200)
            begin errors++; $display("FAIL full_beats got %0d beats, %0d bad want 200", beat_q.size(), beat_bad(0, 200, 0)); end
    endtask

    task automatic test_partial();
        logic ok;
        clear_mon();
        m_ready = 1;
        pulse(0, 0, 1, 1, 8'd9);
        wait_done(200, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL partial_timeout got busy=%b want 0", busy); end
        checks++; if (addr_bad(0, 10, 256) != 0 || addr_q.size() != 10)
            begin errors++; $display("FAIL partial_addrs got %0d reads want 10 from 256", addr_q.size()); end
        checks++; if (beat_bad(0, 10, 256) != 0 || beat_q.size() != 10)
            begin errors++; $display("FAIL partial_beats got %0d beats, %0d bad want 10", beat_q.size(), beat_bad(0, 10, 256)); end
    endtask

    task automatic test_random_ready();
        logic ok;
        clear_mon();
        rand_rdy = 1;
        pulse(1, 0, 0, 0, 0);
        wait_done(3000, ok);
        rand_rdy = 0; m_ready = 1;
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rand_timeout got %0d beats want 200", beat_q.size()); end
        checks++; if (beat_bad(0, 200, 0) != 0 || beat_q.size() != 200)
            begin errors++; $display("FAIL rand_beats got %0d beats, %0d bad want 200", beat_q.size(), beat_bad(0, 200, 0)); end
        checks++; if (stab_err != 0) begin errors++; $display("FAIL rand_stable got %0d violations want 0", stab_err); end
        checks++; if (occ_err != 0) begin errors++; $display("FAIL rand_occupancy got %0d violations want 0", occ_err); end
    endtask

    task automatic test_overrun();
        logic ok;
        clear_mon();
        m_ready = 1;
        pulse(1, 0, 0, 0, 0);
        wait_beats(50, 500, ok);
        pulse(0, 1, 0, 0, 0);
        pulse(0, 0, 1, 0, 8'd5);
        @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
        wait_done(2000, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ovr_timeout got %0d beats want 400", beat_q.size()); end
        checks++; if (beat_bad(0, 200, 0) + beat_bad(200, 200, 256) != 0 || beat_q.size() != 400)
            begin errors++; $display("FAIL ovr_beats got %0d beats want bank0 then bank1 (400)", beat_q.size()); end
        checks++; if (addr_q.size() < 201 || acyc_q[200] - bcyc_q[199] > 2 || addr_q[200] !== 9'd256)
            begin errors++; $display("FAIL ovr_gap got %0d reads want bank1 read at 256 within 2 cycles", addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        logic ok;
        clear_mon();
        m_ready = 1;
        pulse(1, 0, 0, 0, 0);
        wait_beats(50, 500, ok);
        #2 reset = 1;
        #1;
        checks++; if ({m_valid, busy, overrun} !== 3'b000)
            begin errors++; $display("FAIL rstmid got valid=%b busy=%b ovr=%b want 000", m_valid, busy, overrun); end
        @(posedge clk); #1 reset = 0;
        clear_mon();
        pulse(0, 1, 0, 0, 0);
        wait_done(1000, ok);
        checks++; if (addr_bad(0, 200, 256) != 0 || beat_bad(0, 200, 256) != 0 || beat_q.size() != 200)
            begin errors++; $display("FAIL rstmid_bank1 got %0d beats first addr %0d want 200 from 256", beat_q.size(), addr_q.size() > 0 ? int'(addr_q[0]) : -1); end
    endtask

    task automatic test_clamp();
        logic ok;
        int outside = 0;
        clear_mon();
        m_ready = 1;
        pulse(0, 0, 1, 0, 8'd250);
        wait_done(1000, ok);
        foreach (addr_q[i]) if (addr_q[i] > 9'd199) outside++;
        checks++; if (beat_bad(0, 200, 0) != 0 || beat_q.size() != 200)
            begin errors++; $display("FAIL clamp_beats got %0d beats want 200", beat_q.size()); end
        checks++; if (outside != 0 || addr_q.size() != 200)
            begin errors++; $display("FAIL clamp_addrs got %0d reads, %0d outside bank want 200 in 0..199", addr_q.size(), outside); end
    endtask

    task automatic test_simultaneous();
        logic ok;
        clear_mon();
        m_ready = 1;
        pulse(1, 1, 1, 0, 8'd3);
        @(negedge clk);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL simul_ovr got %b want 1", overrun); end
        wait_done(2000, ok);
        checks++; if (beat_bad(0, 200, 0) + beat_bad(200, 200, 256) != 0 || beat_q.size() != 400)
            begin errors++; $display("FAIL simul_beats got %0d beats want bank0 then bank1 (400)", beat_q.size()); end
    endtask

    initial begin
        test_reset();
        test_full_bank0();
        test_partial();
        test_random_ready();
        test_overrun();
        test_reset_mid();
        test_clamp();
        test_simultaneous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
